// File: rtl/rf80386_icache_if.sv
// rf80386_icache_if: FTA 128-bit bus command types and the bus port used by rf80386_icache.
package rf80386_icache_pkg;
    typedef enum logic [4:0] {CMD_NONE = 5'd0, CMD_LOAD = 5'd2} fta_cmd_t;
    typedef struct packed {
        logic [5:0] core;
        logic [2:0] channel;
        logic [3:0] tranid;
    } fta_tranid_t;
    typedef struct packed {
        fta_cmd_t cmd;
        logic cyc;
        logic stb;
        logic we;
        logic [15:0] sel;
        logic [31:0] vadr;
        logic [31:0] padr;
        logic [127:0] dat;
        fta_tranid_t tid;
    } fta_cmd_request128_t;
    typedef struct packed {
        logic ack;
        logic rty;
        fta_tranid_t tid;
        logic [127:0] dat;
    } fta_cmd_response128_t;
endpackage

interface rf80386_icache_if;
    import rf80386_icache_pkg::*;
    fta_cmd_request128_t req;
    fta_cmd_response128_t resp;
    modport master(output req, input resp);
    modport slave(input req, output resp);
endinterface

// File: rtl/rf80386_icache.sv
// rf80386_icache: two-bank direct-mapped instruction-bundle cache with FTA line fill.
// Define RF80386_ICACHE_INV_EN to let inv_i flash-invalidate the cache.
module rf80386_icache
    import rf80386_icache_pkg::*;
#(
    parameter logic [5:0] CORENO = 6'd1,
    parameter logic [2:0] CID = 3'd2,
    parameter int LINES = 128,
    parameter logic [4:0] RTY_WAIT = 5'd8,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input logic clk_i,
    input logic rst_i,
    input logic [31:0] csip,
    input logic inv_i,
    output logic [127:0] ibundle,
    output logic ihit,
    rf80386_icache_if.master ftam
);
    localparam int LW = $clog2(LINES);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, BACKOFF} state_t;
    state_t state, state_n;
    logic [127:0] dat0 [LINES];
    logic [127:0] dat1 [LINES];
    logic [26-LW:0] tag0 [LINES];
    logic [26-LW:0] tag1 [LINES];
    logic [LINES-1:0] val0, val1;
    logic [27:0] a, line;
    logic [26:0] ev, od;
    logic [127:0] d0, d1;
    logic [255:0] pair;
    logic [3:0] tid_cnt, cur_tid;
    logic [7:0] timer;
    logic [4:0] bo;
    logic inv, inv_pend, hit0, hit1, miss_a, miss_b, ok, fill, wr;
`ifdef RF80386_ICACHE_INV_EN
    assign inv = inv_i;
`else
    assign inv = inv_i & 1'b0;
`endif
    // ev/od are the even/odd line addresses shifted right by one: index in the low bits, tag above
    assign a = csip[31:4];
    assign od = a[27:1];
    assign ev = a[27:1] + 27'(a[0]);
    assign d0 = dat0[ev[LW-1:0]];
    assign d1 = dat1[od[LW-1:0]];
    assign hit0 = val0[ev[LW-1:0]] && tag0[ev[LW-1:0]] == ev[26:LW];
    assign hit1 = val1[od[LW-1:0]] && tag1[od[LW-1:0]] == od[26:LW];
    assign ihit = hit0 && hit1;
    assign miss_a = a[0] ? !hit1 : !hit0;
    assign miss_b = a[0] ? !hit0 : !hit1;
    assign pair = a[0] ? {d0, d1} : {d1, d0};
    assign ibundle = 128'(pair >> {csip[3:0], 3'b000});
    assign ok = ftam.resp.tid == {CORENO, CID, cur_tid};
    assign fill = state == WAIT && ftam.resp.ack && ok;
    assign wr = fill && !inv_pend && !inv;
    always_comb begin
        ftam.req = '0;
        ftam.req.tid.core = CORENO;
        ftam.req.tid.channel = CID;
        if (state == REQ) begin
            ftam.req.cyc = 1'b1;
            ftam.req.stb = 1'b1;
            ftam.req.cmd = CMD_LOAD;
            ftam.req.sel = 16'hFFFF;
            ftam.req.vadr = {line, 4'h0};
            ftam.req.padr = {line, 4'h0};
            ftam.req.tid.tranid = tid_cnt;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = (miss_a || miss_b) ? REQ : IDLE;
            REQ: state_n = WAIT;
            WAIT: state_n = fill ? IDLE : (ok && ftam.resp.rty) ? BACKOFF : timer == TIMEOUT ? REQ : WAIT;
            BACKOFF: state_n = bo == RTY_WAIT - 5'd1 ? REQ : BACKOFF;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            val0 <= '0;
            val1 <= '0;
            line <= '0;
            tid_cnt <= 4'd1;
            cur_tid <= '0;
            timer <= '0;
            bo <= '0;
            inv_pend <= 1'b0;
        end else begin
            state <= state_n;
            timer <= state == WAIT ? timer + 8'd1 : 8'd0;
            bo <= state == BACKOFF ? bo + 5'd1 : 5'd0;
            // an invalidate seen mid-fill poisons that fill until the FSM is back in IDLE
            inv_pend <= state != IDLE && state_n != IDLE && (inv_pend || inv);
            if (state == IDLE)
                line <= miss_a ? a : a + 28'd1;
            if (state == REQ) begin
                cur_tid <= tid_cnt;
                tid_cnt <= tid_cnt == 4'd15 ? 4'd1 : tid_cnt + 4'd1;
            end
            if (inv) begin
                val0 <= '0;
                val1 <= '0;
            end else if (wr && line[0])
                val1[line[LW:1]] <= 1'b1;
            else if (wr)
                val0[line[LW:1]] <= 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr && line[0]) begin
            dat1[line[LW:1]] <= ftam.resp.dat;
            tag1[line[LW:1]] <= line[27:LW+1];
        end else if (wr) begin
            dat0[line[LW:1]] <= ftam.resp.dat;
            tag0[line[LW:1]] <= line[27:LW+1];
        end
    end
endmodule
